// File: rtl/gpu_ew_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpu_ew_pkg
// Description : Shared types and helpers for the element-wise matrix engine.
//               ew_op_t    - 3-bit ALU operation select
//               ew_state_t - sequencer states
//               lane_mask  - per-lane enable for a beat starting at elem_idx
// Revision    : 1.0 - initial release
// ============================================================================
package gpu_ew_pkg;

    localparam int c_MAX_LANES = 32;

    typedef enum logic [2:0] {
        EW_ADD = 3'd0,
        EW_SUB = 3'd1,
        EW_MUL = 3'd2,
        EW_MIN = 3'd3,
        EW_MAX = 3'd4,
        EW_AND = 3'd5,
        EW_OR  = 3'd6,
        EW_XOR = 3'd7
    } ew_op_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_A   = 3'd1,
        ST_WAIT_A = 3'd2,
        ST_RD_B   = 3'd3,
        ST_WAIT_B = 3'd4,
        ST_WR_C   = 3'd5,
        ST_FIN    = 3'd6
    } ew_state_t;

    // Lane k is live when elem_idx + k < length. Bits at or above 'lanes'
    // are always 0; callers keep only the low 'lanes' bits.
    function automatic logic [c_MAX_LANES-1:0] lane_mask(
        input logic [31:0] elem_idx,
        input logic [31:0] length,
        input int          lanes
    );
        logic [c_MAX_LANES-1:0] m;
        m = '0;
        for (int k = 0; k < c_MAX_LANES; k++) begin
            m[k] = (k < lanes) && ((elem_idx + 32'(k)) < length);
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ew_lane_alu.sv
`default_nettype none
// ============================================================================
// Module      : ew_lane_alu
// Description : Combinational single-lane ALU for the element-wise engine.
//               Optional macro MAT_EW_SAT_EN: ADD/MUL saturate to all-ones,
//               SUB clamps to zero. Without it every op wraps mod 2^DATA_W.
// Ports       : op     - operation select (ew_op_t)
//               a, b   - operands
//               result - op(a, b)
// Revision    : 1.0 - initial release
// ============================================================================
module ew_lane_alu
    import gpu_ew_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  ew_op_t            op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result
);

    logic [DATA_W-1:0] w_add;
    logic [DATA_W-1:0] w_sub;
    logic [DATA_W-1:0] w_mul;

`ifdef MAT_EW_SAT_EN
    logic [DATA_W:0]     w_sum;
    logic [2*DATA_W-1:0] w_prod;

    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

    assign w_add = w_sum[DATA_W] ? {DATA_W{1'b1}} : w_sum[DATA_W-1:0];
    assign w_sub = (a < b) ? '0 : (a - b);
    // Any bit set in the upper half means the product does not fit.
    assign w_mul = (|w_prod[2*DATA_W-1:DATA_W]) ? {DATA_W{1'b1}}
                                                 : w_prod[DATA_W-1:0];
`else
    assign w_add = a + b;
    assign w_sub = a - b;
    assign w_mul = a * b;
`endif

    always_comb begin
        result = '0;
        case (op)
            EW_ADD:  result = w_add;
            EW_SUB:  result = w_sub;
            EW_MUL:  result = w_mul;
            EW_MIN:  result = (a < b) ? a : b;
            EW_MAX:  result = (a > b) ? a : b;
            EW_AND:  result = a & b;
            EW_OR:   result = a | b;
            EW_XOR:  result = a ^ b;
            default: result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mat_ew_engine.sv
`default_nettype none
// ============================================================================
// Module      : mat_ew_engine
// Description : Element-wise matrix engine, C[i] = op(A[i], B[i]), streaming
//               LANES-wide beats over a request/grant scratchpad port.
//               Optional macro MAT_EW_SAT_EN enables saturating ADD/SUB/MUL
//               inside ew_lane_alu.
// Ports       : clk, rst_n              - clock, async active-low reset
//               start, op, base_a/b/c,
//               length                 - dispatch, sampled on start in IDLE
//               busy, done             - handshake (done is a 1-cycle pulse)
//               mem_req/we/addr/be/
//               wdata, mem_gnt         - scratchpad request channel
//               mem_rvalid, mem_rdata  - scratchpad read return
// Revision    : 1.0 - initial release
// ============================================================================
module mat_ew_engine
    import gpu_ew_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [2:0]              op,
    input  logic [ADDR_W-1:0]       base_a,
    input  logic [ADDR_W-1:0]       base_b,
    input  logic [ADDR_W-1:0]       base_c,
    input  logic [LEN_W-1:0]        length,
    output logic                    busy,
    output logic                    done,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [LANES-1:0]        mem_be,
    output logic [LANES*DATA_W-1:0] mem_wdata,
    input  logic                    mem_gnt,
    input  logic                    mem_rvalid,
    input  logic [LANES*DATA_W-1:0] mem_rdata
);

    ew_state_t               r_state;
    ew_state_t               w_next;
    ew_op_t                  r_op;
    logic [ADDR_W-1:0]       r_base_a;
    logic [ADDR_W-1:0]       r_base_b;
    logic [ADDR_W-1:0]       r_base_c;
    logic [LEN_W-1:0]        r_len;
    // One extra bit so elem_idx + LANES never wraps past a full-length run.
    logic [LEN_W:0]          r_idx;
    logic [LEN_W:0]          w_idx_next;
    logic [LANES*DATA_W-1:0] r_a;
    logic [LANES*DATA_W-1:0] r_b;
    logic                    r_busy;
    logic                    r_done;

    logic                    w_accept;
    logic                    w_cap_a;
    logic                    w_cap_b;
    logic                    w_adv;

    logic [c_MAX_LANES-1:0]  w_mask_full;
    logic                    w_unused_mask;
    logic [LANES-1:0]        w_mask;
    logic [LANES*DATA_W-1:0] w_wdata;
    logic [ADDR_W-1:0]       w_idx_addr;

    assign w_mask_full   = lane_mask(32'(r_idx), 32'(r_len), LANES);
    assign w_mask        = w_mask_full[LANES-1:0];
    assign w_unused_mask = ^w_mask_full;
    assign w_idx_next    = r_idx + (LEN_W+1)'(LANES);
    assign w_idx_addr    = ADDR_W'(r_idx);

    // Per-lane ALU; disabled lanes drive zero so partial beats carry no junk.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [DATA_W-1:0] w_res;

        ew_lane_alu #(
            .DATA_W (DATA_W)
        ) u_alu (
            .op     (r_op),
            .a      (r_a[k*DATA_W +: DATA_W]),
            .b      (r_b[k*DATA_W +: DATA_W]),
            .result (w_res)
        );

        assign w_wdata[k*DATA_W +: DATA_W] = w_mask[k] ? w_res : '0;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and memory-port outputs. Request outputs are decoded from
    // registered state only, so they stay stable while waiting for mem_gnt.
    always_comb begin
        w_next    = r_state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_be    = '0;
        mem_wdata = '0;
        w_accept  = 1'b0;
        w_cap_a   = 1'b0;
        w_cap_b   = 1'b0;
        w_adv     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = (length == '0) ? ST_FIN : ST_RD_A;
                end
            end
            ST_RD_A: begin
                mem_req  = 1'b1;
                mem_addr = r_base_a + w_idx_addr;
                mem_be   = w_mask;
                if (mem_gnt) w_next = ST_WAIT_A;
            end
            ST_WAIT_A: begin
                if (mem_rvalid) begin
                    w_cap_a = 1'b1;
                    w_next  = ST_RD_B;
                end
            end
            ST_RD_B: begin
                mem_req  = 1'b1;
                mem_addr = r_base_b + w_idx_addr;
                mem_be   = w_mask;
                if (mem_gnt) w_next = ST_WAIT_B;
            end
            ST_WAIT_B: begin
                if (mem_rvalid) begin
                    w_cap_b = 1'b1;
                    w_next  = ST_WR_C;
                end
            end
            ST_WR_C: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = r_base_c + w_idx_addr;
                mem_be    = w_mask;
                mem_wdata = w_wdata;
                if (mem_gnt) begin
                    w_adv  = 1'b1;
                    w_next = (w_idx_next >= {1'b0, r_len}) ? ST_FIN : ST_RD_A;
                end
            end
            ST_FIN: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Datapath and handshake registers. busy/done are registered, so the
    // done pulse lands one cycle after FIN together with busy falling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= EW_ADD;
            r_base_a <= '0;
            r_base_b <= '0;
            r_base_c <= '0;
            r_len    <= '0;
            r_idx    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == ST_FIN);
            if (w_accept) begin
                r_op     <= ew_op_t'(op);
                r_base_a <= base_a;
                r_base_b <= base_b;
                r_base_c <= base_c;
                r_len    <= length;
                r_idx    <= '0;
                r_busy   <= 1'b1;
            end else if (r_state == ST_FIN) begin
                r_busy <= 1'b0;
            end
            if (w_cap_a) r_a   <= mem_rdata;
            if (w_cap_b) r_b   <= mem_rdata;
            if (w_adv)   r_idx <= w_idx_next;
        end
    end

    assign busy = r_busy;
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mat_ew_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_mat_ew_engine
// Description : Self-checking bench for mat_ew_engine. A scratchpad model
//               with configurable grant stalls and read latency serves the
//               DUT; a reference computes expected C contents, latency and
//               handshake timing. Honours MAT_EW_SAT_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mat_ew_engine;

    localparam int LANES  = 4;
    localparam int DATA_W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [2:0]   op;
    logic [7:0]   base_a, base_b, base_c, length;
    logic         busy, done;
    logic         mem_req, mem_we;
    logic [7:0]   mem_addr;
    logic [3:0]   mem_be;
    logic [127:0] mem_wdata;
    logic         mem_gnt, mem_rvalid;
    logic [127:0] mem_rdata;

    mat_ew_engine #(
        .LANES (LANES), .DATA_W (DATA_W), .ADDR_W (8), .LEN_W (8)
    ) dut (
        .clk (clk), .rst_n (rst_n), .start (start), .op (op),
        .base_a (base_a), .base_b (base_b), .base_c (base_c), .length (length),
        .busy (busy), .done (done),
        .mem_req (mem_req), .mem_we (mem_we), .mem_addr (mem_addr),
        .mem_be (mem_be), .mem_wdata (mem_wdata), .mem_gnt (mem_gnt),
        .mem_rvalid (mem_rvalid), .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- scratchpad model ----------------
    logic [31:0]  mem [256];
    int           stall_fixed  = 0;   // <0: random 0..max_stall
    int           max_stall    = 0;
    int           rdelay_fixed = 1;   // <=0: random 1..3
    int           rd_cnt       = 0;
    logic [127:0] rd_buf;
    bit           in_req       = 0;
    int           stall_left   = 0;
    logic [7:0]   hold_addr;
    logic [3:0]   hold_be;
    logic         hold_we;
    logic [127:0] hold_wd;
    int           req_cycles   = 0;
    int           grant_cnt    = 0;
    bit           first_rd_seen = 0;
    logic [7:0]   first_rd_addr;
    logic [3:0]   last_wr_be;

    initial begin
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            if (!rst_n) begin
                rd_cnt = 0;
                in_req = 0;
            end else begin
                if (rd_cnt > 0) begin
                    rd_cnt--;
                    if (rd_cnt == 0) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = rd_buf;
                    end
                end
                if (mem_req) begin
                    req_cycles++;
                    if (!in_req) begin
                        in_req     = 1;
                        hold_addr  = mem_addr;
                        hold_be    = mem_be;
                        hold_we    = mem_we;
                        hold_wd    = mem_wdata;
                        stall_left = (stall_fixed >= 0) ? stall_fixed
                                                        : int'($urandom_range(0, max_stall));
                    end else begin
                        check("hold_addr", 64'(mem_addr), 64'(hold_addr));
                        check("hold_be", 64'(mem_be), 64'(hold_be));
                        check("hold_we", 64'(mem_we), 64'(hold_we));
                        check("hold_wdata", 64'(mem_wdata ^ hold_wd), 64'(0));
                    end
                    if (stall_left > 0) begin
                        stall_left--;
                    end else begin
                        in_req  = 0;
                        mem_gnt = 1'b1;
                        grant_cnt++;
                        if (mem_we) begin
                            last_wr_be = mem_be;
                            for (int k = 0; k < LANES; k++) begin
                                if (mem_be[k])
                                    mem[8'(mem_addr + 8'(k))] = mem_wdata[k*32 +: 32];
                                else
                                    check("wdata_off_lane", 64'(mem_wdata[k*32 +: 32]), 64'(0));
                            end
                        end else begin
                            if (!first_rd_seen) begin
                                first_rd_seen = 1;
                                first_rd_addr = mem_addr;
                            end
                            for (int k = 0; k < LANES; k++)
                                rd_buf[k*32 +: 32] = mem[8'(mem_addr + 8'(k))];
                            rd_cnt = (rdelay_fixed > 0) ? rdelay_fixed
                                                        : int'($urandom_range(1, 3));
                        end
                    end
                end
            end
        end
    end

    // ---------------- reference ----------------
    function automatic logic [31:0] ref_op(input int opi, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] s;
        case (opi)
            0: begin
                s = {32'd0, a} + {32'd0, b};
`ifdef MAT_EW_SAT_EN
                if (s > 64'hFFFF_FFFF) s = 64'hFFFF_FFFF;
`endif
                return s[31:0];
            end
            1: begin
`ifdef MAT_EW_SAT_EN
                if (a < b) return 32'd0;
`endif
                return a - b;
            end
            2: begin
                s = {32'd0, a} * {32'd0, b};
`ifdef MAT_EW_SAT_EN
                if (s > 64'hFFFF_FFFF) s = 64'hFFFF_FFFF;
`endif
                return s[31:0];
            end
            3: return (a < b) ? a : b;
            4: return (a > b) ? a : b;
            5: return a & b;
            6: return a | b;
            default: return a ^ b;
        endcase
    endfunction

    // Dispatch one operation and check results, handshake and timing.
    // extra_start pulses a conflicting start mid-run, which must be ignored.
    task automatic run_op(input int opi, input logic [7:0] ba, input logic [7:0] bb,
                          input logic [7:0] bc, input logic [7:0] len,
                          input bit extra_start);
        logic [31:0] exp_mem [256];
        int cyc, busy_cyc, diffs, exp_lat;
        bit chk_lat;
        for (int i = 0; i < 256; i++) exp_mem[i] = mem[i];
        for (int i = 0; i < int'(len); i++)
            exp_mem[8'(bc + 8'(i))] = ref_op(opi, mem[8'(ba + 8'(i))], mem[8'(bb + 8'(i))]);
        chk_lat = (stall_fixed == 0) && (rdelay_fixed == 1);
        exp_lat = (len == 0) ? 2 : 5 * ((int'(len) + 3) / 4) + 2;

        @(negedge clk);
        req_cycles = 0; grant_cnt = 0; first_rd_seen = 0;
        start = 1'b1; op = 3'(opi);
        base_a = ba; base_b = bb; base_c = bc; length = len;
        cyc = 0; busy_cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (extra_start && cyc == 3) begin
                start = 1'b1; op = 3'(opi + 1);
                base_a = 8'($urandom); base_b = 8'($urandom);
                base_c = 8'($urandom); length = 8'($urandom_range(1, 255));
            end else begin
                start = 1'b0;
            end
            if (!done && busy) busy_cyc++;
        end while (!done && cyc < 3000);
        start = 1'b0;
        check("done_seen", 64'(done), 64'(1));
        check("busy_at_done", 64'(busy), 64'(0));
        check("busy_cycles", 64'(busy_cyc), 64'(cyc - 1));
        if (chk_lat) check("done_latency", 64'(cyc), 64'(exp_lat));
        if (len == 0) check("no_mem_traffic", 64'(req_cycles), 64'(0));
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'(0));
        for (int i = 0; i < int'(len); i++)
            check($sformatf("C[%0d]", 8'(bc + 8'(i))), 64'(mem[8'(bc + 8'(i))]),
                  64'(exp_mem[8'(bc + 8'(i))]));
        diffs = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) diffs++;
        check("stray_writes", 64'(diffs), 64'(0));
    endtask

    task automatic setup_add6();
        for (int i = 0; i < 6; i++) begin
            mem[16 + i] = 32'(i);
            mem[64 + i] = 32'(5 * i);
        end
        for (int i = 128; i < 136; i++) mem[i] = 32'hDEAD;
    endtask

    initial begin
        int t;
        logic [7:0] ba;
        rst_n = 1'b0; start = 1'b0; op = '0;
        base_a = '0; base_b = '0; base_c = '0; length = '0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_req", 64'(mem_req), 64'(0));
        check("rst_we", 64'(mem_we), 64'(0));
        check("rst_addr", 64'(mem_addr), 64'(0));
        check("rst_be", 64'(mem_be), 64'(0));
        check("rst_wdata_zero", 64'(mem_wdata != 0), 64'(0));
        @(negedge clk); rst_n = 1'b1;

        // ADD, length 6 with immediate memory
        setup_add6();
        run_op(0, 8'd16, 8'd64, 8'd128, 8'd6, 0);
        for (int i = 0; i < 6; i++) check("add6_val", 64'(mem[128 + i]), 64'(6 * i));
        check("add6_tail134", 64'(mem[134]), 64'(32'hDEAD));
        check("add6_tail135", 64'(mem[135]), 64'(32'hDEAD));
        check("add6_tail_be", 64'(last_wr_be), 64'(4'b0011));

        // length 0
        run_op(7, 8'd10, 8'd20, 8'd30, 8'd0, 0);

        // back-pressure: same results as the no-stall run
        setup_add6();
        stall_fixed = 3; rdelay_fixed = 2;
        run_op(0, 8'd16, 8'd64, 8'd128, 8'd6, 0);
        for (int i = 0; i < 6; i++) check("add6_bp_val", 64'(mem[128 + i]), 64'(6 * i));
        check("add6_bp_tail_be", 64'(last_wr_be), 64'(4'b0011));
        stall_fixed = 0; rdelay_fixed = 1;

        // SUB underflow and MUL overflow boundaries
        mem[40] = 32'd0; mem[41] = 32'd1;
        run_op(1, 8'd40, 8'd41, 8'd42, 8'd1, 0);
`ifdef MAT_EW_SAT_EN
        check("sub_underflow", 64'(mem[42]), 64'(32'h0000_0000));
`else
        check("sub_underflow", 64'(mem[42]), 64'(32'hFFFF_FFFF));
`endif
        mem[44] = 32'h0001_0000; mem[45] = 32'h0001_0000;
        run_op(2, 8'd44, 8'd45, 8'd46, 8'd1, 0);
`ifdef MAT_EW_SAT_EN
        check("mul_overflow", 64'(mem[46]), 64'(32'hFFFF_FFFF));
`else
        check("mul_overflow", 64'(mem[46]), 64'(32'h0000_0000));
`endif

        // address wrap with MIN and MAX
        run_op(3, 8'd254, 8'd100, 8'd180, 8'd4, 0);
        check("wrap_first_rd", 64'(first_rd_addr), 64'(254));
        run_op(4, 8'd254, 8'd100, 8'd190, 8'd4, 0);
        check("wrap_first_rd_max", 64'(first_rd_addr), 64'(254));

        // reset in WAIT_B, then a run with an ignored mid-run start
        rdelay_fixed = 3;
        @(negedge clk);
        grant_cnt = 0;
        start = 1'b1; op = 3'd0; base_a = 8'd16; base_b = 8'd64; base_c = 8'd128; length = 8'd8;
        @(negedge clk); start = 1'b0;
        t = 0;
        while (grant_cnt < 2 && t < 100) begin
            @(negedge clk); #2; t++;
        end
        check("reach_wait_b", 64'(grant_cnt), 64'(2));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", 64'(busy), 64'(0));
        check("async_rst_req", 64'(mem_req), 64'(0));
        check("async_rst_addr", 64'(mem_addr), 64'(0));
        check("async_rst_be", 64'(mem_be), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rdelay_fixed = 1;
        run_op(6, 8'd16, 8'd64, 8'd200, 8'd7, 1);

        // randomized runs, including exact in-place aliasing
        stall_fixed = -1; max_stall = 2; rdelay_fixed = 0;
        for (int r = 0; r < 24; r++) begin
            ba = 8'($urandom);
            run_op(int'($urandom_range(0, 7)), ba, 8'(ba + 8'd64),
                   ($urandom_range(0, 3) == 0) ? ba : 8'(ba + 8'd128),
                   8'($urandom_range(0, 24)), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
